// File: rtl/twf_rnd_sat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | twf_rnd_sat_pkg                                                    |
// | Fixed-point formats and framing constants for the round/sat stage. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package twf_rnd_sat_pkg;

    localparam int DIN_WIDTH  = 23;
    localparam int DIN_FRAC   = 13;
    localparam int DOUT_WIDTH = 14;
    localparam int DOUT_FRAC  = 6;
    localparam int SHIFT      = DIN_FRAC - DOUT_FRAC;
    localparam int DEPTH      = 16;
    localparam int NUM_BUS    = 4;
    localparam int N_LANES    = NUM_BUS * DEPTH;
    localparam int BLK_BEATS  = 32;
    localparam int BEAT_W     = $clog2(BLK_BEATS);
    localparam int CNT_WIDTH  = 12;
    // Rounded value before clipping; one guard bit keeps the +bias from wrapping
    localparam int RND_WIDTH  = DIN_WIDTH + 1 - SHIFT;

    typedef logic signed [DIN_WIDTH-1:0]  din_lane_t;
    typedef logic signed [DOUT_WIDTH-1:0] dout_lane_t;
    typedef logic signed [RND_WIDTH-1:0]  rnd_t;

    localparam int SAT_MAX_I = 2**(DOUT_WIDTH-1) - 1;
    localparam int SAT_MIN_I = -(2**(DOUT_WIDTH-1));
    localparam dout_lane_t SAT_MAX = dout_lane_t'(SAT_MAX_I);
    localparam dout_lane_t SAT_MIN = dout_lane_t'(SAT_MIN_I);
    localparam logic signed [DIN_WIDTH:0] RND_BIAS = (DIN_WIDTH+1)'(2**(SHIFT-1));
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/twf_rnd_sat_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | twf_rnd_sat_if                                                     |
// | Product lanes in, rounded lanes plus frame status out.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface twf_rnd_sat_if;
    import twf_rnd_sat_pkg::*;

    logic                           din_valid;
    din_lane_t  [DEPTH-1:0]         din_R_add;
    din_lane_t  [DEPTH-1:0]         din_Q_add;
    din_lane_t  [DEPTH-1:0]         din_R_sub;
    din_lane_t  [DEPTH-1:0]         din_Q_sub;

    logic                           dout_valid;
    dout_lane_t [DEPTH-1:0]         dout_R_add;
    dout_lane_t [DEPTH-1:0]         dout_Q_add;
    dout_lane_t [DEPTH-1:0]         dout_R_sub;
    dout_lane_t [DEPTH-1:0]         dout_Q_sub;
    logic                           dout_last;
    logic       [CNT_WIDTH-1:0]     blk_sat_cnt;
    logic                           sat_sticky;

    modport master (
        output din_valid, din_R_add, din_Q_add, din_R_sub, din_Q_sub,
        input  dout_valid, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub,
        input  dout_last, blk_sat_cnt, sat_sticky
    );

    modport slave (
        input  din_valid, din_R_add, din_Q_add, din_R_sub, din_Q_sub,
        output dout_valid, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub,
        output dout_last, blk_sat_cnt, sat_sticky
    );

endinterface
`default_nettype wire

// File: rtl/twf_rnd_sat_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rnd_sat_lane                                                       |
// | Round-half-up <10.13> -> <8.6> and clip one lane; flags clipping.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rnd_sat_lane
    import twf_rnd_sat_pkg::*;
(
    input  din_lane_t  x,
    output dout_lane_t y,
    output logic       sat
);

    logic signed [DIN_WIDTH:0] w_ext;
    logic signed [DIN_WIDTH:0] w_sum;
    rnd_t                      w_rnd;

    assign w_ext = {x[DIN_WIDTH-1], x};
    assign w_sum = w_ext + RND_BIAS;
    assign w_rnd = rnd_t'(w_sum >>> SHIFT);

    always_comb begin
        y   = dout_lane_t'(w_rnd);
        sat = 1'b0;
        if (w_rnd > rnd_t'(SAT_MAX_I)) begin
            y   = SAT_MAX;
            sat = 1'b1;
        end else if (w_rnd < rnd_t'(SAT_MIN_I)) begin
            y   = SAT_MIN;
            sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/twf_rnd_sat.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | twf_rnd_sat                                                        |
// | 64-lane round/saturate pipeline with frame framing and sat counts. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module twf_rnd_sat
    import twf_rnd_sat_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    twf_rnd_sat_if.slave  bus
);

    din_lane_t            w_din [NUM_BUS][DEPTH];
    dout_lane_t           w_y   [NUM_BUS][DEPTH];
    logic [N_LANES-1:0]   w_sat;

    dout_lane_t           r_y   [NUM_BUS][DEPTH];
    logic [N_LANES-1:0]   r_sat;
    logic                 r_valid_s1;

    logic [BEAT_W-1:0]    r_beat;
    logic [CNT_WIDTH-1:0] r_run;
    logic [CNT_WIDTH-1:0] w_pop;
    logic [CNT_WIDTH:0]   w_sum;
    logic [CNT_WIDTH-1:0] w_total;
    logic                 w_last;

    always_comb begin
        for (int l = 0; l < DEPTH; l++) begin
            w_din[0][l] = bus.din_R_add[l];
            w_din[1][l] = bus.din_Q_add[l];
            w_din[2][l] = bus.din_R_sub[l];
            w_din[3][l] = bus.din_Q_sub[l];
        end
    end

    for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
        for (genvar l = 0; l < DEPTH; l++) begin : g_lane
            rnd_sat_lane u_lane (
                .x   (w_din[b][l]),
                .y   (w_y[b][l]),
                .sat (w_sat[b*DEPTH + l])
            );
        end
    end

    // Stage 1: rounded/clipped lanes and their sat flags, held across gaps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_s1 <= 1'b0;
            r_sat      <= '0;
            for (int b = 0; b < NUM_BUS; b++) begin
                for (int l = 0; l < DEPTH; l++) begin
                    r_y[b][l] <= '0;
                end
            end
        end else begin
            r_valid_s1 <= bus.din_valid;
            if (bus.din_valid) begin
                r_y   <= w_y;
                r_sat <= w_sat;
            end
        end
    end

    // Frame total including the beat now leaving stage 1, clamped at all-ones
    assign w_pop   = CNT_WIDTH'($countones(r_sat));
    assign w_sum   = {1'b0, r_run} + {1'b0, w_pop};
    assign w_total = w_sum[CNT_WIDTH] ? CNT_MAX : w_sum[CNT_WIDTH-1:0];
    assign w_last  = (r_beat == BEAT_W'(BLK_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dout_valid  <= 1'b0;
            bus.dout_last   <= 1'b0;
            bus.blk_sat_cnt <= '0;
            bus.sat_sticky  <= 1'b0;
            r_beat          <= '0;
            r_run           <= '0;
            for (int l = 0; l < DEPTH; l++) begin
                bus.dout_R_add[l] <= '0;
                bus.dout_Q_add[l] <= '0;
                bus.dout_R_sub[l] <= '0;
                bus.dout_Q_sub[l] <= '0;
            end
        end else begin
            bus.dout_valid <= r_valid_s1;
            bus.dout_last  <= r_valid_s1 & w_last;
            if (r_valid_s1) begin
                for (int l = 0; l < DEPTH; l++) begin
                    bus.dout_R_add[l] <= r_y[0][l];
                    bus.dout_Q_add[l] <= r_y[1][l];
                    bus.dout_R_sub[l] <= r_y[2][l];
                    bus.dout_Q_sub[l] <= r_y[3][l];
                end
                if (w_last) begin
                    r_beat          <= '0;
                    r_run           <= '0;
                    bus.blk_sat_cnt <= w_total;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                    r_run  <= w_total;
                end
                if (|r_sat) begin
                    bus.sat_sticky <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/twf_rnd_sat.md
Name: twf_rnd_sat

Overview:
- Downstream neighbour of the 16-lane twiddle multiplier. Consumes its four full-precision <10.13> product buses (R/Q, add/sub branches, 16 lanes each).
- Rounds and saturates every lane to the next butterfly stage's <8.6> input format.
- Tracks 512-point frame boundaries and counts saturation events per frame.
- Two-cycle pipelined datapath, streaming, no backpressure.

Parameters:
DIN_WIDTH, 23, input product width <10.13>
DIN_FRAC, 13, input fractional bits
DOUT_WIDTH, 14, output width <8.6>
DOUT_FRAC, 6, output fractional bits; SHIFT = DIN_FRAC-DOUT_FRAC = 7
DEPTH, 16, lanes per beat
BLK_BEATS, 32, beats per frame (512/16)
CNT_WIDTH, 12, saturation counter width (max 4*16*32 = 2048 events)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
din_valid  in  1  beat qualifier, aligned with din_* (multiplier output register)
din_R_add, din_Q_add, din_R_sub, din_Q_sub  in  signed DIN_WIDTH x DEPTH each  products
dout_valid  out  1  output beat qualifier
dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub  out  signed DOUT_WIDTH x DEPTH each  rounded/saturated lanes
dout_last  out  1  high with the final beat (beat 31) of a frame
blk_sat_cnt  out  CNT_WIDTH  saturation events in the frame just finished; valid while dout_last=1
sat_sticky  out  1  set by any saturation since reset, never auto-cleared

Behaviour:
- Reset: clk and rst_n are one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge: all dout_* lanes=0, dout_valid=0, dout_last=0, blk_sat_cnt=0, sat_sticky=0, beat counter=0, running sat count=0. Mid-frame reset discards the partial frame; the next valid beat is beat 0.
- Stage 1 (cycle after din_valid): per lane r = (x + 2^(SHIFT-1)) >>> SHIFT. Compute in DIN_WIDTH+1 bits so that +64 never wraps. Rounding is round-half-up, i.e. ties toward +inf. Register r and valid_s1.
- Stage 2: saturate r to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] = [-8192, 8191]. Per-lane sat bit = clipped. Register the outputs and dout_valid = valid_s1.
- Latency: exactly 2 clk from din_valid to dout_valid. Throughput 1 beat/clk. Gaps in din_valid propagate as gaps.
- Output hold: when a stage's valid is 0, its data registers hold their previous value. Only valid changes.
- Beat counter:
  - Advances on stage-2 valid beats only.
  - Range 0..BLK_BEATS-1, wraps to 0 after 31.
  - dout_last = dout_valid and counter==31.
- Saturation counting:
  - Per beat, popcount the 64 sat bits.
  - Running count accumulates over the frame.
  - On the last beat, blk_sat_cnt = running + this beat's popcount, and running clears to 0 in the same cycle.
  - blk_sat_cnt holds until the next frame end.
  - The counter saturates at 2^CNT_WIDTH-1. Never wraps.
- sat_sticky: set in the cycle any sat bit is 1 on a valid beat.
- Simultaneous events: a valid last beat with saturation both finalises blk_sat_cnt and sets sat_sticky. Reset has priority over everything.

Decomposition:
- Shared package fft_pkg holds:
  - fixed-point constants: DIN/DOUT widths and fracs, SHIFT
  - BLK_BEATS, SAT_MAX, SAT_MIN
  - a lane_t typedef for each format
- One sub-module, rnd_sat_lane: combinational round+clip of a single value, with a sat flag output. Instantiate 4*DEPTH copies via generate.
- The top level owns the registers, beat counter, popcount and counters.

Test Plan:
- Rounding: lane inputs 64, 63, -64, -65, 192 with din_valid=1 -> two cycles later outputs 1, 0, 0, -1, 2; no saturation.
- Saturation: input 4194303 -> 8191, and input -4194304 -> -8192, both flagged. Input 1048511 (->8191 exactly) is not flagged. sat_sticky rises on the first flagged beat.
- Framing: 32 consecutive valid beats -> dout_last only on the 32nd output beat. Repeat 32 beats with a 3-cycle din_valid gap inserted at beat 10 -> dout_last still on the 32nd valid beat, and the gap appears on dout_valid.
- Counting: a frame where beat 5 has 3 saturating lanes and beat 31 has 64 -> blk_sat_cnt=67 with dout_last. The next frame with no saturation -> blk_sat_cnt=0 at its end.
- Reset mid-frame: rst_n=0 for 1 cycle after 20 beats -> all outputs 0. The next 32 beats form a full frame with dout_last on beat 32.
- Hold: din_valid=0 with changing din -> dout lanes unchanged, dout_valid=0.
